hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates per-stage write-enable (`*_Wr`) and flush (`*_Flush`) controls for the PC, ID, EXE, MEM and WB pipeline registers.
- Sources it resolves: load-use hazards, multi-cycle divider occupancy, I/D-cache miss stalls, taken branches and exceptions/ERET.
- Sits beside the datapath; pipeline registers give Flush priority over Wr.

Parameters:
- DIV_CYCLES, 32, number of cycles the iterative divider occupies EXE after a start.
- CNT_W, 6, width of the divider down-counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- EXE_MemRead  in  1  instruction in EXE is a load.
- EXE_rt  in  5  load destination register in EXE.
- EXE_DivStart  in  1  DIV/DIVU entering execution in EXE.
- IF_ICacheBusy  in  1  instruction fetch not yet returned.
- MEM_DCacheBusy  in  1  data access in MEM not yet complete.
- EXE_BranchTaken  in  1  branch/jump in EXE redirects the PC.
- MEM_ExcValid  in  1  exception or ERET committed in MEM.
- PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  register enables.
- ID_Flush, EXE_Flush, MEM_Flush  out  1 each  register clears.
- DivBusy  out  1  divider occupying EXE.

Behaviour:
- Reset (rst==0 at posedge):
  - FSM to RUN; counter = 0; BrPending = 0.
  - All `*_Wr` = 1, all `*_Flush` = 0, DivBusy = 0.
- Outputs are combinational from FSM state plus current inputs; zero-cycle latency.
- FSM states: RUN, DIV_WAIT, EXC_FLUSH.
- RUN, evaluated in priority order (highest first):
  1. MEM_ExcValid:
     - ID_Flush = EXE_Flush = MEM_Flush = 1; all Wr = 1.
     - Clear BrPending; next state EXC_FLUSH.
  2. MEM_DCacheBusy:
     - All Wr = 0 (full freeze).
  3. EXE_DivStart:
     - Load counter with DIV_CYCLES-1; next state DIV_WAIT.
     - This cycle: PC_Wr = ID_Wr = EXE_Wr = 0, MEM_Flush = 1.
  4. IF_ICacheBusy:
     - PC_Wr = ID_Wr = 0; EXE_Flush = 1 (bubble).
     - If EXE_BranchTaken, set BrPending = 1.
  5. Load-use:
     - Condition: EXE_MemRead and EXE_rt != 0 and (EXE_rt == ID_rs or EXE_rt == ID_rt).
     - PC_Wr = ID_Wr = 0; EXE_Flush = 1.
  6. EXE_BranchTaken or BrPending:
     - ID_Flush = 1 (kills the wrong-path fetch; the delay slot in ID advances normally).
     - Clear BrPending.
  7. Otherwise: all Wr = 1, no flush.
- DIV_WAIT:
  - DivBusy = 1; PC_Wr = ID_Wr = EXE_Wr = 0; MEM_Flush = 1.
  - Counter decrements each cycle. At counter == 0: return to RUN and release EXE that cycle (EXE_Wr = 1).
  - MEM_DCacheBusy in DIV_WAIT: full freeze, and the counter holds.
  - MEM_ExcValid in DIV_WAIT: abort the divide, same handling as RUN rule 1, counter cleared.
- EXC_FLUSH:
  - One cycle; ID_Flush = 1 (clears the fetch from the old PC). Then RUN.
- Simultaneous events:
  - Exception beats everything.
  - D-cache freeze beats branch; the branch input is re-sampled after the freeze because EXE holds.
  - Load-use and branch cannot coincide (both need EXE).
- Counter arithmetic:
  - Unsigned CNT_W bits; never decrements below 0.
  - DIV_CYCLES == 1 gives a single stall cycle.
- Reset mid-divide: immediate RUN, counter cleared, no residual stall.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output port StallCnt [31:0] plus internal counters.
  - StallCnt increments every cycle in which PC_Wr == 0 and rst == 1.
  - Saturates at 32'hFFFF_FFFF; cleared to 0 on reset.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with random inputs -> all Wr = 1, all Flush = 0, DivBusy = 0; then rst = 1 with idle inputs -> unchanged.
- Load-use: EXE_MemRead = 1, EXE_rt = 5, ID_rs = 5 -> PC_Wr = ID_Wr = 0, EXE_Flush = 1 for exactly that cycle; repeat with EXE_rt = 0 -> no stall.
- Divider: DIV_CYCLES = 32, pulse EXE_DivStart -> DivBusy high 32 cycles, EXE_Wr = 0 for 32 cycles, release on the 33rd cycle; insert a 3-cycle MEM_DCacheBusy mid-divide -> total stall 35 cycles.
- Branch under I-miss: EXE_BranchTaken = 1 while IF_ICacheBusy = 1 -> no ID_Flush; when IF_ICacheBusy drops -> ID_Flush = 1 exactly one cycle.
- Exception during divide: MEM_ExcValid at divide cycle 10 -> ID/EXE/MEM_Flush = 1 that cycle, ID_Flush = 1 next cycle, DivBusy = 0 from next cycle, then normal run.
- HAZARD_STALL_CNT_EN: 1 load-use stall + 32-cycle divide -> StallCnt = 33 (the divide start cycle counts); reset -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencer for the 5-stage core.
//
// Produces per-stage write enables (*_Wr) and clears (*_Flush) for the PC,
// ID, EXE, MEM and WB pipeline registers. It resolves load-use hazards,
// divider occupancy of EXE, I/D-cache miss stalls, taken branches and
// exceptions/ERET. The pipeline registers give Flush priority over Wr.
//
// Ports:
//   clk, rst          core clock, synchronous active-low reset
//   ID_rs, ID_rt      source register fields of the instruction in ID
//   EXE_MemRead/EXE_rt  load in EXE and its destination register
//   EXE_DivStart      DIV/DIVU starting in EXE
//   IF_ICacheBusy     fetch outstanding
//   MEM_DCacheBusy    data access outstanding (freezes the whole pipe)
//   EXE_BranchTaken   redirect from EXE
//   MEM_ExcValid      exception/ERET committed in MEM
//   PC_Wr..WB_Wr      register enables
//   ID/EXE/MEM_Flush  register clears
//   StallCnt          cycles with PC_Wr low (only with HAZARD_STALL_CNT_EN)
//   DivBusy           divider occupying EXE
//
// Build option: define HAZARD_STALL_CNT_EN to add the StallCnt output.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUN       | normal issue; hazards resolved by priority each cycle
// DIV_WAIT  | divider owns EXE; front end held, bubbles into MEM
// EXC_FLUSH | one cycle after an exception, kills the stale fetch in ID

module hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EXE_MemRead,
  input  logic [4:0]  EXE_rt,
  input  logic        EXE_DivStart,
  input  logic        IF_ICacheBusy,
  input  logic        MEM_DCacheBusy,
  input  logic        EXE_BranchTaken,
  input  logic        MEM_ExcValid,
  output logic        PC_Wr,
  output logic        ID_Wr,
  output logic        EXE_Wr,
  output logic        MEM_Wr,
  output logic        WB_Wr,
  output logic        ID_Flush,
  output logic        EXE_Flush,
  output logic        MEM_Flush,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] StallCnt,
`endif
  output logic        DivBusy
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_pend_q, br_pend_d;
  logic             load_use;

  assign load_use = EXE_MemRead && (EXE_rt != 5'd0) &&
                    ((EXE_rt == ID_rs) || (EXE_rt == ID_rt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_pend_q <= br_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    br_pend_d = br_pend_q;
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    EXE_Wr    = 1'b1;
    MEM_Wr    = 1'b1;
    WB_Wr     = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Flush = 1'b0;
    MEM_Flush = 1'b0;
    DivBusy   = 1'b0;

    // Outputs stay at their idle values while reset is asserted.
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (MEM_ExcValid) begin
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            br_pend_d = 1'b0;
            state_d   = EXC_FLUSH;
          end else if (MEM_DCacheBusy) begin
            // Full freeze; a branch in EXE is seen again once it releases.
            PC_Wr  = 1'b0;
            ID_Wr  = 1'b0;
            EXE_Wr = 1'b0;
            MEM_Wr = 1'b0;
            WB_Wr  = 1'b0;
          end else if (EXE_DivStart) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
            cnt_d     = DIV_LOAD;
            state_d   = DIV_WAIT;
          end else if (IF_ICacheBusy) begin
            // Bubble into EXE; remember a redirect so the late fetch is killed.
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Flush = 1'b1;
            if (EXE_BranchTaken) br_pend_d = 1'b1;
          end else if (load_use) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Flush = 1'b1;
          end else if (EXE_BranchTaken || br_pend_q) begin
            // Delay slot in ID advances; only the wrong-path fetch dies.
            ID_Flush  = 1'b1;
            br_pend_d = 1'b0;
          end
        end

        DIV_WAIT: begin
          DivBusy = 1'b1;
          if (MEM_ExcValid) begin
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            br_pend_d = 1'b0;
            cnt_d     = '0;
            state_d   = EXC_FLUSH;
          end else if (MEM_DCacheBusy) begin
            // Freeze holds the count so the divide still gets its full time.
            PC_Wr  = 1'b0;
            ID_Wr  = 1'b0;
            EXE_Wr = 1'b0;
            MEM_Wr = 1'b0;
            WB_Wr  = 1'b0;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
            cnt_d     = cnt_q - 1'b1;
          end
        end

        EXC_FLUSH: begin
          if (MEM_ExcValid) begin
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            br_pend_d = 1'b0;
          end else begin
            ID_Flush = 1'b1;
            state_d  = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (!PC_Wr && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int DIV = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs, ID_rt, EXE_rt;
  logic EXE_MemRead, EXE_DivStart, IF_ICacheBusy, MEM_DCacheBusy;
  logic EXE_BranchTaken, MEM_ExcValid;
  logic PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
  logic ID_Flush, EXE_Flush, MEM_Flush, DivBusy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] StallCnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EXE_MemRead(EXE_MemRead), .EXE_rt(EXE_rt),
    .EXE_DivStart(EXE_DivStart), .IF_ICacheBusy(IF_ICacheBusy),
    .MEM_DCacheBusy(MEM_DCacheBusy), .EXE_BranchTaken(EXE_BranchTaken),
    .MEM_ExcValid(MEM_ExcValid),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush),
`ifdef HAZARD_STALL_CNT_EN
    .StallCnt(StallCnt),
`endif
    .DivBusy(DivBusy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pipeline situation as plain flags and a remaining-cycle count.
  bit      m_div, m_excf, m_br;
  int      m_left;
  longint  m_stall;

  // Tallies of observed DUT outputs, used by the directed scenarios.
  int t_exe0, t_busy, t_idfl;

  task automatic cycle();
    logic [4:0] e_wr;
    logic [2:0] e_fl;
    logic       e_busy, lu;
    bit         n_div, n_excf, n_br;
    int         n_left;
    longint     n_stall;
    #1;
    e_wr = 5'b11111; e_fl = 3'b000; e_busy = 1'b0;
    n_div = m_div; n_excf = m_excf; n_br = m_br; n_left = m_left; n_stall = m_stall;
    lu = EXE_MemRead && EXE_rt != 0 && (EXE_rt == ID_rs || EXE_rt == ID_rt);
    if (!rst) begin
      n_div = 0; n_excf = 0; n_br = 0; n_left = 0; n_stall = 0;
    end else if (m_div) begin
      e_busy = 1'b1;
      if (MEM_ExcValid) begin
        e_fl = 3'b111; n_div = 0; n_left = 0; n_excf = 1; n_br = 0;
      end else if (MEM_DCacheBusy) e_wr = 5'b00000;
      else if (m_left == 0) n_div = 0;
      else begin
        e_wr = 5'b00011; e_fl = 3'b001; n_left = m_left - 1;
      end
    end else if (m_excf) begin
      if (MEM_ExcValid) begin e_fl = 3'b111; n_br = 0; end
      else begin e_fl = 3'b100; n_excf = 0; end
    end else begin
      if (MEM_ExcValid) begin e_fl = 3'b111; n_br = 0; n_excf = 1; end
      else if (MEM_DCacheBusy) e_wr = 5'b00000;
      else if (EXE_DivStart) begin
        e_wr = 5'b00011; e_fl = 3'b001; n_div = 1; n_left = DIV - 1;
      end else if (IF_ICacheBusy) begin
        e_wr = 5'b00111; e_fl = 3'b010;
        if (EXE_BranchTaken) n_br = 1;
      end else if (lu) begin
        e_wr = 5'b00111; e_fl = 3'b010;
      end else if (EXE_BranchTaken || m_br) begin
        e_fl = 3'b100; n_br = 0;
      end
    end
    if (rst && !e_wr[4] && m_stall < 64'hFFFF_FFFF) n_stall = m_stall + 1;

    chk("ctl{wr,fl,busy}", {23'd0, PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
                            ID_Flush, EXE_Flush, MEM_Flush, DivBusy},
        {23'd0, e_wr, e_fl, e_busy});
`ifdef HAZARD_STALL_CNT_EN
    if (rst) chk("stallcnt", StallCnt, m_stall[31:0]);
`endif
    t_exe0 += int'(!EXE_Wr);
    t_busy += int'(DivBusy);
    t_idfl += int'(ID_Flush);

    @(posedge clk);
    m_div = n_div; m_excf = n_excf; m_br = n_br; m_left = n_left; m_stall = n_stall;
    @(negedge clk);
  endtask

  task automatic idle();
    ID_rs = 5'd1; ID_rt = 5'd2; EXE_rt = 5'd3; EXE_MemRead = 0;
    EXE_DivStart = 0; IF_ICacheBusy = 0; MEM_DCacheBusy = 0;
    EXE_BranchTaken = 0; MEM_ExcValid = 0;
  endtask

  task automatic rand_in();
    ID_rs = 5'($urandom_range(0, 7));
    ID_rt = 5'($urandom_range(0, 7));
    EXE_rt = 5'($urandom_range(0, 7));
    EXE_MemRead = ($urandom_range(0, 2) == 0);
    EXE_DivStart = ($urandom_range(0, 29) == 0);
    IF_ICacheBusy = ($urandom_range(0, 4) == 0);
    MEM_DCacheBusy = ($urandom_range(0, 7) == 0);
    EXE_BranchTaken = ($urandom_range(0, 5) == 0);
    MEM_ExcValid = ($urandom_range(0, 39) == 0);
  endtask

  task automatic tally_clear();
    t_exe0 = 0; t_busy = 0; t_idfl = 0;
  endtask

  initial begin
    m_div = 0; m_excf = 0; m_br = 0; m_left = 0; m_stall = 0;
    tally_clear();
    rst = 1'b0;
    idle();
    @(negedge clk);

    // Reset with random inputs, then idle.
    repeat (2) begin rand_in(); cycle(); end
    rst = 1'b1; idle();
    repeat (2) cycle();

    // Load-use hit, then the same pattern with r0 (no stall).
    EXE_MemRead = 1; EXE_rt = 5'd5; ID_rs = 5'd5;
    #1;
    chk("lu_pc_wr", PC_Wr, 0);
    chk("lu_exe_flush", EXE_Flush, 1);
    cycle();
    idle(); cycle();
    EXE_MemRead = 1; EXE_rt = 5'd0; ID_rs = 5'd0;
    #1;
    chk("lu_r0_pc_wr", PC_Wr, 1);
    cycle();
    idle(); cycle();

    // Plain divide.
    tally_clear();
    EXE_DivStart = 1; cycle(); idle();
    repeat (40) cycle();
    chk("div_exe_stall", t_exe0, 32);
    chk("div_busy", t_busy, 32);
`ifdef HAZARD_STALL_CNT_EN
    chk("stallcnt_33", StallCnt, 33);
`endif

    // Divide with a 3-cycle D-cache freeze in the middle.
    tally_clear();
    EXE_DivStart = 1; cycle(); idle();
    repeat (10) cycle();
    MEM_DCacheBusy = 1; repeat (3) cycle();
    idle(); repeat (30) cycle();
    chk("div_dc_exe_stall", t_exe0, 35);
    chk("div_dc_busy", t_busy, 35);

    // Branch during an I-miss: flush deferred to the cycle the miss clears.
    tally_clear();
    IF_ICacheBusy = 1; EXE_BranchTaken = 1;
    repeat (2) cycle();
    chk("br_imiss_no_flush", t_idfl, 0);
    idle();
    repeat (3) cycle();
    chk("br_after_imiss_flush", t_idfl, 1);

    // Exception on divide cycle 10.
    EXE_DivStart = 1; cycle(); idle();
    repeat (8) cycle();
    MEM_ExcValid = 1;
    #1;
    chk("exc_div_flush", {ID_Flush, EXE_Flush, MEM_Flush}, 3'b111);
    cycle(); idle();
    tally_clear();
    #1;
    chk("exc_next_id_flush", ID_Flush, 1);
    repeat (5) cycle();
    chk("exc_busy_after", t_busy, 0);

    // Reset in the middle of a divide.
    EXE_DivStart = 1; cycle(); idle();
    repeat (5) cycle();
    rst = 1'b0; cycle(); rst = 1'b1;
    tally_clear();
    repeat (3) cycle();
    chk("rst_mid_div_busy", t_busy, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst = ($urandom_range(0, 99) != 0);
      cycle();
    end

    rst = 1'b0; idle(); cycle();
    rst = 1'b1; cycle();
`ifdef HAZARD_STALL_CNT_EN
    chk("stallcnt_reset", StallCnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
